// File: rtl/ahbl_excl_monitor.sv
// ahbl_excl_monitor
// -----------------------------------------------------------------------------
// Global exclusive-access monitor sitting on one crossbar slave port. Keeps
// one address reservation per master (slot index = 8-bit master ID), decides
// pass/fail for exclusive stores, turns failed exclusive stores into IDLE
// toward the slave, and drives the exclusive-OK indication back upstream.
// Everything else passes straight through combinationally.
//
// Optional feature macro: EXCL_MON_FAIL_CNT_EN
//   defined   -> adds fail_cnt, a 16-bit saturating count of failed
//                exclusive stores
//   undefined -> no fail_cnt port, no counter
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   src_hready        global HREADY from upstream
//   src_hready_resp   HREADYOUT to upstream (= dst_hready_resp)
//   src_hresp         HRESP to upstream (= dst_hresp)
//   src_haddr/hwrite/htrans/hexcl/hmaster  address-phase controls
//   src_hexokay       exclusive success, valid at end of data phase
//   dst_hready        = src_hready
//   dst_hready_resp   slave HREADYOUT
//   dst_hresp         slave HRESP
//   dst_haddr/hwrite  = src_haddr/src_hwrite
//   dst_htrans        src_htrans, or IDLE for a failed exclusive store
//   fail_cnt          failed exclusive store count (macro only)
// -----------------------------------------------------------------------------
module ahbl_excl_monitor #(
   parameter int N_MASTERS    = 2,
   parameter int W_ADDR       = 32,
   parameter int GRANULE_LOG2 = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              src_hready,
   output logic              src_hready_resp,
   output logic              src_hresp,
   input  logic [W_ADDR-1:0] src_haddr,
   input  logic              src_hwrite,
   input  logic [1:0]        src_htrans,
   input  logic              src_hexcl,
   input  logic [7:0]        src_hmaster,
   output logic              src_hexokay,
   output logic              dst_hready,
   input  logic              dst_hready_resp,
   input  logic              dst_hresp,
   output logic [W_ADDR-1:0] dst_haddr,
   output logic              dst_hwrite,
   output logic [1:0]        dst_htrans
`ifdef EXCL_MON_FAIL_CNT_EN
   ,
   output logic [15:0]       fail_cnt
`endif
);

   localparam int W_TAG = W_ADDR - GRANULE_LOG2;

   logic [W_TAG-1:0]     tag;
   logic                 accept;
   logic                 id_ok;
   logic                 pass;
   logic                 excl_rd;
   logic                 excl_wr;
   logic                 excl_fail;
   logic                 plain_wr;
   logic                 err_rd;

   logic [N_MASTERS-1:0] id_hit;    // slot addressed by src_hmaster
   logic [N_MASTERS-1:0] tag_hit;   // slot tag equals current address tag
   logic [N_MASTERS-1:0] dp_hit;    // slot addressed by data-phase master
   logic [N_MASTERS-1:0] res_v;

   logic                 dp_excl_reg;
   logic                 dp_ok_reg;
   logic                 dp_rd_reg;
   logic [7:0]           dp_id_reg;

   assign tag    = src_haddr[W_ADDR-1:GRANULE_LOG2];
   assign accept = src_hready & src_htrans[1];

   // An out-of-range ID hits no slot, so id_ok and pass fall out naturally.
   assign id_ok = |id_hit;
   assign pass  = |(id_hit & res_v & tag_hit);

   assign excl_rd   = accept &  src_hexcl & ~src_hwrite;
   assign excl_wr   = accept &  src_hexcl &  src_hwrite;
   assign excl_fail = excl_wr & ~pass;
   assign plain_wr  = accept & ~src_hexcl &  src_hwrite;
   assign err_rd    = dp_excl_reg & dp_rd_reg & dst_hresp;

   generate
      for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_slot
         logic             v_reg;
         logic [W_TAG-1:0] tag_reg;
         logic             set_now;
         logic             clr_now;

         assign id_hit[gi]  = (src_hmaster == 8'(gi));
         assign dp_hit[gi]  = (dp_id_reg == 8'(gi));
         assign tag_hit[gi] = (tag_reg == tag);
         assign res_v[gi]   = v_reg;

         assign set_now = excl_rd & id_hit[gi];
         // Clears OR together: matching store (plain or passing exclusive),
         // own failed exclusive store, error on own exclusive read.
         assign clr_now = ((plain_wr | (excl_wr & pass)) & tag_hit[gi])
                        | (excl_fail & id_hit[gi])
                        | (err_rd & dp_hit[gi]);

         // A set from the current address phase wins over any clear.
         always_ff @(posedge clk) begin
            if (rst) begin
               v_reg   <= 1'b0;
               tag_reg <= '0;
            end else if (set_now) begin
               v_reg   <= 1'b1;
               tag_reg <= tag;
            end else if (clr_now) begin
               v_reg   <= 1'b0;
            end
         end
      end
   endgenerate

   // Data-phase context, held through wait states.
   always_ff @(posedge clk) begin
      if (rst) begin
         dp_excl_reg <= 1'b0;
         dp_ok_reg   <= 1'b0;
         dp_rd_reg   <= 1'b0;
         dp_id_reg   <= '0;
      end else if (src_hready) begin
         dp_excl_reg <= accept & src_hexcl;
         dp_ok_reg   <= src_hwrite ? pass : id_ok;
         dp_rd_reg   <= ~src_hwrite;
         dp_id_reg   <= src_hmaster;
      end
   end

   assign src_hexokay = dp_excl_reg & dp_ok_reg & ~dst_hresp;

   assign src_hready_resp = dst_hready_resp;
   assign src_hresp       = dst_hresp;
   assign dst_hready      = src_hready;
   assign dst_haddr       = src_haddr;
   assign dst_hwrite      = src_hwrite;
   assign dst_htrans      = excl_fail ? 2'b00 : src_htrans;

`ifdef EXCL_MON_FAIL_CNT_EN
   logic [15:0] fail_cnt_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         fail_cnt_reg <= '0;
      end else if (excl_fail && fail_cnt_reg != 16'hFFFF) begin
         fail_cnt_reg <= fail_cnt_reg + 16'd1;
      end
   end

   assign fail_cnt = fail_cnt_reg;
`endif

endmodule

// File: tb/tb_ahbl_excl_monitor.sv
// Testbench for ahbl_excl_monitor: a master/slave driver with a reservation
// model kept as plain arrays, checked every cycle, plus literal expectations
// for the directed scenarios and a randomized run.
module tb_ahbl_excl_monitor;

   localparam int NM = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        src_hready;
   logic        src_hready_resp;
   logic        src_hresp;
   logic [31:0] src_haddr;
   logic        src_hwrite;
   logic [1:0]  src_htrans;
   logic        src_hexcl;
   logic [7:0]  src_hmaster;
   logic        src_hexokay;
   logic        dst_hready;
   logic        dst_hready_resp;
   logic        dst_hresp;
   logic [31:0] dst_haddr;
   logic        dst_hwrite;
   logic [1:0]  dst_htrans;
`ifdef EXCL_MON_FAIL_CNT_EN
   logic [15:0] fail_cnt;
`endif

   always #5 clk = ~clk;

   ahbl_excl_monitor #(.N_MASTERS(NM), .W_ADDR(32), .GRANULE_LOG2(2)) dut (
      .clk             (clk),
      .rst             (rst),
      .src_hready      (src_hready),
      .src_hready_resp (src_hready_resp),
      .src_hresp       (src_hresp),
      .src_haddr       (src_haddr),
      .src_hwrite      (src_hwrite),
      .src_htrans      (src_htrans),
      .src_hexcl       (src_hexcl),
      .src_hmaster     (src_hmaster),
      .src_hexokay     (src_hexokay),
      .dst_hready      (dst_hready),
      .dst_hready_resp (dst_hready_resp),
      .dst_hresp       (dst_hresp),
      .dst_haddr       (dst_haddr),
      .dst_hwrite      (dst_hwrite),
      .dst_htrans      (dst_htrans)
`ifdef EXCL_MON_FAIL_CNT_EN
      ,
      .fail_cnt        (fail_cnt)
`endif
   );

   typedef struct {
      bit          idle;
      int          m;
      logic [31:0] addr;
      bit          excl;
      bit          wr;
      int          waits;
      bit          err;
      int          sn;
   } item_t;

   item_t q[$];

   int checks   = 0;
   int failures = 0;

   // reservation model
   bit        m_v   [NM];
   bit [29:0] m_tag [NM];
   int        m_fail;

   // data-phase model
   bit    dp_act;
   item_t dp_it;
   bit    dp_ok;
   int    dp_i;

   int obs_ok  [1024];
   int obs_sup [1024];
   int sn_next = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic push(bit idle, int m, logic [31:0] a, bit excl, bit wr,
                       int waits, bit err, output int sn);
      item_t it;
      it.idle = idle; it.m = m; it.addr = a; it.excl = excl; it.wr = wr;
      it.waits = waits; it.err = err; it.sn = sn_next;
      sn = sn_next;
      obs_ok[sn_next]  = -1;
      obs_sup[sn_next] = -1;
      sn_next++;
      q.push_back(it);
   endtask

   task automatic cycle_step();
      bit          r_rdy, r_err, have, acc, idok, ps;
      item_t       it;
      logic [1:0]  htr, exp_htr;
      bit [29:0]   tg;
      bit          exp_ok;
      @(negedge clk);
      // slave response for the transfer in data phase
      if (!dp_act) begin
         r_rdy = 1; r_err = 0;
      end else if (dp_i < dp_it.waits) begin
         r_rdy = 0; r_err = 0;
      end else if (dp_it.err) begin
         r_rdy = (dp_i != dp_it.waits); r_err = 1;
      end else begin
         r_rdy = 1; r_err = 0;
      end
      dst_hready_resp = r_rdy;
      dst_hresp       = r_err;
      src_hready      = r_rdy;
      have = (q.size() > 0);
      it = '{default:0};
      if (have) it = q[0];
      htr = (have && !it.idle) ? 2'b10 : 2'b00;
      src_htrans  = htr;
      src_haddr   = it.addr;
      src_hwrite  = it.wr;
      src_hexcl   = it.excl;
      src_hmaster = 8'(it.m);
      #1;
      tg   = it.addr[31:2];
      acc  = r_rdy && htr[1];
      idok = (it.m < NM);
      ps   = idok && m_v[it.m % NM] && (m_tag[it.m % NM] == tg);
      exp_htr = (acc && it.excl && it.wr && !ps) ? 2'b00 : htr;
      exp_ok  = dp_act && dp_it.excl && dp_ok && !r_err;
      chk("dst_htrans", dst_htrans, exp_htr);
      chk("src_hexokay", src_hexokay, exp_ok);
      chk("pass_ctrl", {dst_hready, src_hready_resp, src_hresp, dst_hwrite},
          {r_rdy, r_rdy, r_err, it.wr});
      chk("dst_haddr", dst_haddr, it.addr);
`ifdef EXCL_MON_FAIL_CNT_EN
      chk("fail_cnt", fail_cnt, m_fail);
`endif
      if (acc) obs_sup[it.sn] = (dst_htrans == 2'b00);
      if (dp_act && r_rdy) obs_ok[dp_it.sn] = src_hexokay;
      // reservation update: clears first, then an address-phase set on top
      if (dp_act && dp_it.excl && !dp_it.wr && r_err && dp_it.m < NM)
         m_v[dp_it.m] = 0;
      if (acc && it.wr) begin
         if (!it.excl || ps) begin
            for (int k = 0; k < NM; k++)
               if (m_tag[k] == tg) m_v[k] = 0;
         end else begin
            if (idok) m_v[it.m] = 0;
            if (m_fail < 65535) m_fail++;
         end
      end
      if (acc && it.excl && !it.wr && idok) begin
         m_v[it.m]   = 1;
         m_tag[it.m] = tg;
      end
      if (r_rdy) begin
         if (have) void'(q.pop_front());
         dp_act = acc;
         dp_it  = it;
         dp_ok  = it.wr ? ps : idok;
         dp_i   = 0;
      end else begin
         dp_i++;
      end
      @(posedge clk);
   endtask

   task automatic run();
      int budget = 0;
      while ((q.size() > 0 || dp_act) && budget < 20000) begin
         cycle_step();
         budget++;
      end
      checks++;
      if (budget >= 20000) begin
         failures++;
         $display("FAIL run_timeout actual=%0d expected<%0d", budget, 20000);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1;
      src_hready = 1; dst_hready_resp = 1; dst_hresp = 0;
      src_htrans = 2'b00; src_hexcl = 0; src_hwrite = 0;
      src_haddr = 32'h0; src_hmaster = 8'h0;
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("reset_hexokay", src_hexokay, 1'b0);
      chk("reset_htrans", dst_htrans, 2'b00);
`ifdef EXCL_MON_FAIL_CNT_EN
      chk("reset_fail_cnt", fail_cnt, 16'h0);
`endif
      @(posedge clk);
      #1;
      rst = 0;
      for (int k = 0; k < NM; k++) begin m_v[k] = 0; m_tag[k] = '0; end
      m_fail = 0;
      dp_act = 0; dp_i = 0; dp_ok = 0;
      dp_it = '{default:0};
   endtask

   int s0, s1, s2, s3;

   initial begin
      rst = 1;
      do_reset();

      // exclusive pair passes
      push(0, 0, 32'h2000_0100, 1, 0, 0, 0, s0);
      push(0, 0, 32'h2000_0100, 1, 1, 0, 0, s1);
      run();
      chk("t1_rd_ok", obs_ok[s0], 1);
      chk("t1_wr_ok", obs_ok[s1], 1);
      chk("t1_wr_sup", obs_sup[s1], 0);

      // intervening store to same granule kills the reservation
      push(0, 0, 32'h100, 1, 0, 0, 0, s0);
      push(0, 1, 32'h100, 0, 1, 0, 0, s1);
      push(0, 0, 32'h100, 1, 1, 0, 0, s2);
      run();
      chk("t2_wr_sup", obs_sup[s2], 1);
      chk("t2_wr_ok", obs_ok[s2], 0);
`ifdef EXCL_MON_FAIL_CNT_EN
      chk("t2_fail_cnt", fail_cnt, 16'd1);
`endif

      // store to neighbouring granule leaves it intact
      push(0, 0, 32'h100, 1, 0, 0, 0, s0);
      push(0, 1, 32'h104, 0, 1, 0, 0, s1);
      push(0, 0, 32'h100, 1, 1, 0, 0, s2);
      run();
      chk("t3_wr_ok", obs_ok[s2], 1);
      chk("t3_wr_sup", obs_sup[s2], 0);
`ifdef EXCL_MON_FAIL_CNT_EN
      chk("t3_fail_cnt", fail_cnt, 16'd1);
`endif

      // no reservation; out-of-range master
      push(0, 1, 32'h200, 1, 1, 0, 0, s0);
      push(0, 2, 32'h200, 1, 0, 0, 0, s1);
      run();
      chk("t4_wr_sup", obs_sup[s0], 1);
      chk("t4_wr_ok", obs_ok[s0], 0);
      chk("t4_id2_ok", obs_ok[s1], 0);

      // exclusive read with wait states and ERROR
      push(0, 0, 32'h300, 1, 0, 3, 1, s0);
      push(0, 0, 32'h300, 1, 1, 0, 0, s1);
      run();
      chk("t5_rd_ok", obs_ok[s0], 0);
      chk("t5_wr_sup", obs_sup[s1], 1);

      // passing store by one master clears the other's reservation
      push(0, 0, 32'h400, 1, 0, 0, 0, s0);
      push(0, 1, 32'h400, 1, 0, 1, 0, s1);
      push(0, 1, 32'h400, 1, 1, 0, 0, s2);
      push(0, 0, 32'h400, 1, 1, 0, 0, s3);
      run();
      chk("t6_m1_ok", obs_ok[s2], 1);
      chk("t6_m0_sup", obs_sup[s3], 1);

      // error clear and fresh set in the same cycle: set wins
      push(0, 0, 32'h600, 1, 0, 0, 1, s0);
      push(0, 0, 32'h600, 1, 0, 0, 0, s1);
      push(0, 0, 32'h600, 1, 1, 0, 0, s2);
      run();
      chk("t7_wr_ok", obs_ok[s2], 1);

      // reset between reservation and store
      push(0, 0, 32'h500, 1, 0, 0, 0, s0);
      run();
      do_reset();
      push(0, 0, 32'h500, 1, 1, 0, 0, s1);
      run();
      chk("t8_wr_sup", obs_sup[s1], 1);

      // randomized traffic
      for (int n = 0; n < 500; n++) begin
         logic [31:0] base;
         case ($urandom_range(3))
            0: base = 32'h1000;
            1: base = 32'h1004;
            2: base = 32'h1008;
            default: base = 32'h2000;
         endcase
         push($urandom_range(7) == 0, $urandom_range(3),
              base | 32'($urandom_range(3)),
              $urandom_range(2) != 0, $urandom_range(1) == 1,
              $urandom_range(3) == 0 ? $urandom_range(2) : 0,
              $urandom_range(7) == 0, s0);
      end
      run();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
